// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite responder backed by a word-addressed SRAM array.
// Serves NONSEQ/SEQ word reads and writes with WAIT_STATES wait cycles per
// OKAY data phase. Illegal accesses get a two-cycle ERROR response.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   HSEL, HADDR,      address phase: select, byte address,
//   HTRANS, HWRITE,   transfer type, direction,
//   HSIZE             transfer size (word only)
//   HWDATA            write data (data phase)
//   HREADY            bus-wide ready
//   HRDATA            read data (data phase)
//   HREADYOUT, HRESP  this slave's ready and response
module ahb_slave_mem #(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          DEPTH       = 256,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
  parameter int unsigned          WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP
);

  localparam int unsigned      IDX_W     = $clog2(DEPTH);
  localparam int unsigned      LSB       = $clog2(DATA_W / 8);
  localparam logic [2:0]       WORD_SIZE = 3'(LSB);
  localparam logic [ADDR_W:0]  SPAN      = (ADDR_W + 1)'(DEPTH << LSB);
  localparam logic [1:0]       RESP_OKAY  = 2'b00;
  localparam logic [1:0]       RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              pend;
  logic [IDX_W-1:0]  lat_idx;
  logic              lat_write;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              legal;
  logic              accept;
  logic              commit;
  logic              fwd;
  logic              unused_trans;

  assign unused_trans = HTRANS[0];

  always_comb begin
    offset = HADDR - BASE_ADDR;
    idx    = offset[LSB +: IDX_W];
    legal  = (HADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN) &&
             (HADDR[LSB-1:0] == '0) && (HSIZE == WORD_SIZE);
    accept = HSEL && HREADY && HTRANS[1];
    // A pending write sits in IDLE only during its final data-phase cycle,
    // so the edge that ends that cycle is the commit edge.
    commit = pend && (state == IDLE);
    // Zero-wait read accepted on the commit edge of a write to the same
    // word must see the new data, which is not yet in the array.
    fwd    = commit && (lat_idx == idx);
  end

  always_ff @(posedge clk) begin
    if (commit) mem[lat_idx] <= HWDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
      HRDATA    <= '0;
    end else begin
      case (state)
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            // Any earlier write has already committed, so the array is current.
            if (!lat_write) HRDATA <= mem[lat_idx];
          end
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= RESP_ERROR;
        end
        default: begin
          // IDLE and ERR2 both end a data phase and may take a new address.
          state     <= IDLE;
          pend      <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= RESP_OKAY;
          if (accept) begin
            lat_idx   <= idx;
            lat_write <= HWRITE;
            if (!legal) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= RESP_ERROR;
            end else begin
              pend <= HWRITE;
              if (WAIT_STATES != 0) begin
                state     <= WAIT;
                cnt       <= 4'(WAIT_STATES);
                HREADYOUT <= 1'b0;
              end else if (!HWRITE) begin
                HRDATA <= fwd ? HWDATA : mem[idx];
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite responder (slave) backed by a word-addressed SRAM array. It is the target end of the bus driven by the DMA channel master.
- Serves NONSEQ/SEQ reads and writes with a programmable number of wait states.
- Returns a two-cycle ERROR response for illegal accesses.
- Used as source/destination memory model in DMA subsystem benches. Synthesizable as a scratchpad.

Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, data bus width (word size = DATA_W/8 bytes)
- DEPTH, 256, number of DATA_W words in the array
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_STATES, 1, HREADYOUT-low cycles inserted per OKAY data phase (0..15)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- HSEL  input  1  slave select from decoder
- HADDR  input  ADDR_W  byte address (address phase)
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  input  1  1=write, 0=read (address phase)
- HSIZE  input  3  transfer size; only 3'b010 (word) is legal for DATA_W=32
- HWDATA  input  DATA_W  write data (data phase)
- HREADY  input  1  bus-wide ready (muxed HREADYOUT of the active slave)
- HRDATA  output  DATA_W  read data (data phase)
- HREADYOUT  output  1  this slave's ready
- HRESP  output  2  00=OKAY, 01=ERROR

Behaviour:
- Reset (async, any state): HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0, pending-write flag=0. Array contents are not reset. An in-flight write is dropped (not committed).
- Accept: an address phase is accepted on a rising edge where HSEL && HREADY && HTRANS[1]. On acceptance, HADDR and HWRITE are latched.
- Ignored address phases: IDLE/BUSY, or HSEL=0, start no access. The following cycle is OKAY, HREADYOUT=1, and the array is untouched.
- Illegal access: any of the following is illegal:
  - HADDR < BASE_ADDR
  - (HADDR-BASE_ADDR) >= DEPTH*4
  - HADDR[1:0] != 0
  - HSIZE != 3'b010
- Word index: (HADDR-BASE_ADDR)>>2, width clog2(DEPTH).
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - Legal accept with WAIT_STATES>0 -> WAIT; counter loads WAIT_STATES.
  - Legal accept with WAIT_STATES=0 -> stay IDLE; data phase completes next cycle.
  - Illegal accept -> ERR1.
- WAIT: HREADYOUT=0, HRESP=00. Counter decrements each cycle. At counter==1 -> IDLE, so the next cycle is the final data-phase cycle with HREADYOUT=1.
- ERR1: HREADYOUT=0, HRESP=01. Unconditionally -> ERR2.
- ERR2: HREADYOUT=1, HRESP=01.
  - A new accept in this cycle is evaluated exactly as from IDLE (legal -> WAIT or IDLE, illegal -> ERR1).
  - No accept -> IDLE.
- Latency: an OKAY data phase is WAIT_STATES+1 cycles. An ERROR data phase is exactly 2 cycles. HREADYOUT is never low for more than WAIT_STATES cycles (OKAY) or 1 cycle (ERROR).
- Write commit: HWDATA is written to the latched index on the rising edge that ends the data phase (the final cycle, HREADYOUT=1). Errored writes never modify the array.
- Read data: HRDATA is driven with the array word in the final data-phase cycle and holds its value until the next read completes. Reads that error leave HRDATA unchanged.
- Pipelining: the next address phase may be accepted in the final data-phase cycle of the current transfer. Back-to-back accesses with WAIT_STATES=0 sustain one transfer per cycle.
- Write->read forwarding: if a read's address phase coincides with the commit edge of a write to the same index, the read returns that HWDATA, never stale array data.
- HREADY low with HSEL=1 (another slave stalling): no accept, no state change.
- A BUSY inserted between SEQ beats produces zero-wait OKAY and advances nothing.

Test Plan:
- WAIT_STATES=1: NONSEQ write 0x0000_0010 <- 0xDEAD_BEEF, then read same address -> write data phase HREADYOUT 0,1, HRESP=00; read returns 0xDEAD_BEEF after one wait cycle.
- WAIT_STATES=0: 4-beat NONSEQ+SEQ write to 0x00,0x04,0x08,0x0C with data 1..4, immediately followed by a read of 0x0C -> HREADYOUT stays 1 throughout; read returns 4 (forwarding path).
- Read at BASE_ADDR+DEPTH*4 (0x400) -> HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01; array unchanged; next legal read OKAY.
- Misaligned write 0x0000_0006, then a write with HSIZE=3'b001 -> both get the two-cycle ERROR; a read of word 1 returns its prior value.
- BUSY between SEQ beats and HTRANS=IDLE with HSEL=1 -> zero-wait OKAY, no array access.
- Assert rst during WAIT of a write to 0x20 with data 0x55 -> HREADYOUT=1, HRESP=00, HRDATA=0 immediately; a later read of 0x20 returns the pre-write contents.
